// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipeline.
// Turns memory waits, mul/div occupancy, load-use and redirects into PC and pipeline-register stall/flush controls.
module hazard_ctrl #(
    parameter int MDU_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ifid_instr_i,
    input  logic [31:0] idex_instr_i,
    input  logic        idex_memread_i,
    input  logic        branch_taken_i,
    input  logic        jump_i,
    input  logic        mdu_start_i,
    input  logic        dmem_req_i,
    input  logic        dmem_ready_i,
    output logic        pc_write_o,
    output logic        ifid_stall_o,
    output logic        ifid_flush_o,
    output logic        idex_stall_o,
    output logic        idex_flush_o,
    output logic        exmem_stall_o,
    output logic        exmem_flush_o,
    output logic        memwb_flush_o,
    output logic        mdu_busy_o,
    output logic        err_o
);

    typedef enum logic {RUN, MDU} state_t;

    localparam logic [7:0]  CNT_INIT = 8'(MDU_CYCLES - 2);
    localparam logic [15:0] TIMEOUT  = 16'(MEM_TIMEOUT);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] wcnt, wcnt_n;
    logic        err;

    logic [4:0] rs_id, rt_id, rt_ex;
    logic       mem_hold, mdu_hold, load_use, redirect;
    logic       unused_bits;

    assign rs_id = ifid_instr_i[25:21];
    assign rt_id = ifid_instr_i[20:16];
    assign rt_ex = idex_instr_i[20:16];
    assign unused_bits = ^{ifid_instr_i[31:26], ifid_instr_i[15:0],
                           idex_instr_i[31:21], idex_instr_i[15:0]};

    assign mem_hold = dmem_req_i & ~dmem_ready_i;
    assign mdu_hold = ((state == RUN) & mdu_start_i) | ((state == MDU) & (cnt != 8'd0));
    assign load_use = idex_memread_i & (rt_ex != 5'd0) & ((rt_ex == rs_id) | (rt_ex == rt_id));
    assign redirect = branch_taken_i | jump_i;

    // A memory wait freezes the mul/div sequence so it resumes where it left off.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (!mem_hold) begin
            case (state)
                RUN: begin
                    if (mdu_start_i) begin
                        state_n = MDU;
                        cnt_n   = CNT_INIT;
                    end
                end
                MDU: begin
                    if (cnt != 8'd0) cnt_n = cnt - 8'd1;
                    else             state_n = RUN;
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_comb begin
        if (!mem_hold)             wcnt_n = 16'd0;
        else if (wcnt == TIMEOUT)  wcnt_n = wcnt;
        else                       wcnt_n = wcnt + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            cnt   <= 8'd0;
            wcnt  <= 16'd0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            wcnt  <= wcnt_n;
            if (wcnt_n == TIMEOUT) err <= 1'b1;
        end
    end

    // Strict priority: memory wait, mul/div, load-use, redirect; everything held low in reset.
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_stall_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_stall_o = 1'b0;
        exmem_flush_o = 1'b0;
        memwb_flush_o = 1'b0;
        if (!rst_i) begin
            if (mem_hold) begin
                ifid_stall_o  = 1'b1;
                idex_stall_o  = 1'b1;
                exmem_stall_o = 1'b1;
                memwb_flush_o = 1'b1;
            end else if (mdu_hold) begin
                ifid_stall_o  = 1'b1;
                idex_stall_o  = 1'b1;
                exmem_flush_o = 1'b1;
            end else if (load_use) begin
                ifid_stall_o  = 1'b1;
                idex_flush_o  = 1'b1;
            end else if (redirect) begin
                pc_write_o    = 1'b1;
                ifid_flush_o  = 1'b1;
            end else begin
                pc_write_o    = 1'b1;
            end
        end
    end

    assign mdu_busy_o = ~rst_i & (state == MDU);
    assign err_o      = err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed test for hazard_ctrl with MDU_CYCLES=4 and MEM_TIMEOUT=3.
// Output vector: {pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, exmem_flush, memwb_flush, mdu_busy, err}.
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] ifid_instr_i = '0;
    logic [31:0] idex_instr_i = '0;
    logic        idex_memread_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic        jump_i = 1'b0;
    logic        mdu_start_i = 1'b0;
    logic        dmem_req_i = 1'b0;
    logic        dmem_ready_i = 1'b0;
    logic        pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o;
    logic        exmem_stall_o, exmem_flush_o, memwb_flush_o, mdu_busy_o, err_o;

    int total = 0;
    int bad   = 0;

    localparam logic [9:0] ZERO  = 10'b0000000000;
    localparam logic [9:0] NONE  = 10'b1000000000;
    localparam logic [9:0] LU    = 10'b0100100000;
    localparam logic [9:0] REDIR = 10'b1010000000;
    localparam logic [9:0] MDUH  = 10'b0101001000;
    localparam logic [9:0] MEMH  = 10'b0101010100;
    localparam logic [9:0] BUSY  = 10'b0000000010;
    localparam logic [9:0] ERR   = 10'b0000000001;

    localparam logic [31:0] LW_T0    = 32'h8C08_0000; // rt = 8
    localparam logic [31:0] LW_ZERO  = 32'h8C00_0000; // rt = 0
    localparam logic [31:0] ADD_RS8  = 32'h010A_4820; // rs = 8, rt = 10
    localparam logic [31:0] ADD_RT8  = 32'h0148_4820; // rs = 10, rt = 8
    localparam logic [31:0] ADD_NO8  = 32'h012A_4820; // rs = 9, rt = 10
    localparam logic [31:0] ADD_ZERO = 32'h0000_4820; // rs = 0, rt = 0

    hazard_ctrl #(.MDU_CYCLES(4), .MEM_TIMEOUT(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifid_instr_i(ifid_instr_i), .idex_instr_i(idex_instr_i),
        .idex_memread_i(idex_memread_i), .branch_taken_i(branch_taken_i),
        .jump_i(jump_i), .mdu_start_i(mdu_start_i),
        .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .pc_write_o(pc_write_o), .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
        .idex_stall_o(idex_stall_o), .idex_flush_o(idex_flush_o),
        .exmem_stall_o(exmem_stall_o), .exmem_flush_o(exmem_flush_o),
        .memwb_flush_o(memwb_flush_o), .mdu_busy_o(mdu_busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input logic [31:0] ifid, input logic [31:0] idex,
                                 input logic memread, input logic br, input logic jmp,
                                 input logic start, input logic req, input logic rdy);
        ifid_instr_i   = ifid;
        idex_instr_i   = idex;
        idex_memread_i = memread;
        branch_taken_i = br;
        jump_i         = jmp;
        mdu_start_i    = start;
        dmem_req_i     = req;
        dmem_ready_i   = rdy;
    endtask

    task automatic compareNow(input string tag, input logic [9:0] expected);
        logic [9:0] observed;
        observed = {pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
                    exmem_stall_o, exmem_flush_o, memwb_flush_o, mdu_busy_o, err_o};
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Check at the falling edge, then advance to just after the next rising edge.
    task automatic checkOutput(input string tag, input logic [9:0] expected);
        @(negedge clk_i);
        compareNow(tag, expected);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2;
        compareNow("reset_outputs", ZERO);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        applyStimulus('0, '0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle", NONE);

        applyStimulus(ADD_RS8, LW_T0, 1, 0, 0, 0, 0, 0);
        checkOutput("loaduse_rs", LU);
        applyStimulus(ADD_RS8, ADD_NO8, 0, 0, 0, 0, 0, 0);
        checkOutput("loaduse_cleared", NONE);
        applyStimulus(ADD_RT8, LW_T0, 1, 0, 0, 0, 0, 0);
        checkOutput("loaduse_rt", LU);
        applyStimulus(ADD_NO8, LW_T0, 1, 0, 0, 0, 0, 0);
        checkOutput("load_no_dep", NONE);
        applyStimulus(ADD_ZERO, LW_ZERO, 1, 0, 0, 0, 0, 0);
        checkOutput("load_rt_zero", NONE);

        applyStimulus(ADD_NO8, '0, 0, 1, 0, 0, 0, 0);
        checkOutput("branch", REDIR);
        applyStimulus(ADD_RS8, LW_T0, 1, 1, 0, 0, 0, 0);
        checkOutput("branch_loaduse", LU);
        applyStimulus(ADD_RS8, ADD_NO8, 0, 1, 0, 0, 0, 0);
        checkOutput("branch_deferred", REDIR);
        applyStimulus(ADD_NO8, '0, 0, 0, 1, 0, 0, 0);
        checkOutput("jump", REDIR);

        applyStimulus('0, '0, 0, 0, 0, 1, 0, 0);
        checkOutput("mdu_c1", MDUH);
        checkOutput("mdu_c2", MDUH | BUSY);
        applyStimulus('0, '0, 0, 0, 1, 1, 0, 0);
        checkOutput("mdu_c3_jump_held", MDUH | BUSY);
        checkOutput("mdu_c4_release", REDIR | BUSY);
        applyStimulus('0, '0, 0, 0, 0, 0, 0, 0);
        checkOutput("mdu_c5_run", NONE);

        applyStimulus('0, '0, 0, 0, 0, 1, 0, 0);
        checkOutput("mduw_c1", MDUH);
        checkOutput("mduw_c2", MDUH | BUSY);
        applyStimulus('0, '0, 0, 0, 0, 1, 1, 0);
        checkOutput("mduw_wait1", MEMH | BUSY);
        checkOutput("mduw_wait2", MEMH | BUSY);
        applyStimulus('0, '0, 0, 0, 0, 1, 0, 0);
        checkOutput("mduw_cnt_frozen", MDUH | BUSY);
        checkOutput("mduw_release", NONE | BUSY);
        applyStimulus('0, '0, 0, 0, 0, 0, 0, 0);
        checkOutput("mduw_run_no_err", NONE);

        applyStimulus('0, '0, 0, 0, 0, 0, 1, 0);
        checkOutput("wait1", MEMH);
        checkOutput("wait2", MEMH);
        checkOutput("wait3", MEMH);
        applyStimulus('0, '0, 0, 0, 0, 0, 1, 1);
        checkOutput("err_set", NONE | ERR);
        applyStimulus('0, '0, 0, 0, 0, 0, 0, 0);
        checkOutput("err_sticky", NONE | ERR);

        applyStimulus('0, '0, 0, 0, 0, 1, 0, 0);
        checkOutput("rmdu_c1", MDUH | ERR);
        @(negedge clk_i);
        compareNow("rmdu_c2", MDUH | BUSY | ERR);
        #2;
        rst_i = 1'b1;
        #1;
        compareNow("async_reset", ZERO);
        applyStimulus('0, '0, 0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        #1;
        compareNow("reset_held", ZERO);
        rst_i = 1'b0;
        #1;
        compareNow("after_reset", NONE);
        @(posedge clk_i);
        #1;
        checkOutput("after_reset_edge", NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage core. Each cycle it inspects the ID- and EX-stage instructions, branch/jump resolution, the multi-cycle multiply/divide unit and the data-memory handshake. From these it drives PC write-enable plus the stall/flush inputs of IF_ID, ID_EX, EX_MEM and MEM_WB. It holds a small FSM for multi-cycle EX operations and a memory-wait watchdog.

## Interface
- MDU_CYCLES, 4: total EX occupancy of a mul/div instruction in cycles; legal range 2..255.
- MEM_TIMEOUT, 64: consecutive memory-wait cycles that set err_o; legal range 1..65535.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ifid_instr_i  in  32  ID-stage instruction (rs = [25:21], rt = [20:16]).
- idex_instr_i  in  32  EX-stage instruction (rt = [20:16]).
- idex_memread_i  in  1  EX-stage instruction is a load.
- branch_taken_i  in  1  branch in ID resolved taken.
- jump_i  in  1  jump in ID.
- mdu_start_i  in  1  EX-stage instruction is mul/div; held high while it stays in EX.
- dmem_req_i  in  1  MEM stage is issuing a load or store.
- dmem_ready_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC update enable.
- ifid_stall_o, ifid_flush_o  out  1 each  IF_ID controls.
- idex_stall_o, idex_flush_o  out  1 each  ID_EX controls.
- exmem_stall_o, exmem_flush_o  out  1 each  EX_MEM controls.
- memwb_flush_o  out  1  inject a bubble into MEM_WB.
- mdu_busy_o  out  1  FSM is in MDU.
- err_o  out  1  sticky memory-timeout flag.

## Operation
- Pipeline registers give stall priority over flush. This block never asserts stall and flush of the same register in the same cycle.
- Hold conditions are evaluated combinationally (Mealy) from the current state and inputs:
  - mem_hold = dmem_req_i & !dmem_ready_i.
  - mdu_hold = (state RUN & mdu_start_i) | (state MDU & cnt != 0).
  - load_use = idex_memread_i & rt_ex != 0 & (rt_ex == rs_id | rt_ex == rt_id).
  - redirect = branch_taken_i | jump_i.
- Output actions, strict priority; the first true condition wins and all unlisted outputs are 0:
  1. mem_hold: pc_write 0; ifid_stall, idex_stall, exmem_stall, memwb_flush 1.
  2. mdu_hold: pc_write 0; ifid_stall, idex_stall, exmem_flush 1.
  3. load_use: pc_write 0; ifid_stall, idex_flush 1.
  4. redirect: pc_write 1; ifid_flush 1.
  5. none: pc_write 1.
- FSM states RUN and MDU, with an 8-bit down-counter cnt:
  - In RUN, mdu_start_i & !mem_hold: go to MDU and load cnt <= MDU_CYCLES-2.
  - In MDU with !mem_hold: if cnt != 0, decrement cnt; if cnt == 0, go to RUN.
  - In MDU, mdu_start_i is ignored, so the same instruction cannot retrigger.
  - mem_hold freezes both the state and cnt.
- Watchdog: 16-bit wcnt increments on every mem_hold cycle, saturating at MEM_TIMEOUT, and clears on any cycle without mem_hold. When wcnt reaches MEM_TIMEOUT, err_o sets and stays set until reset.
- mdu_busy_o = (state == MDU).

## Timing
- Reset (async, asserted): state RUN, cnt 0, wcnt 0, err_o 0. All outputs are forced to 0, including pc_write_o, while rst_i is high. On deassertion, the outputs follow the rules above from the next evaluation.
- Stall/flush outputs are combinational and take effect at the same-cycle clock edge. State, cnt, wcnt and err_o are registered.
- Mul/div: exactly MDU_CYCLES-1 hold cycles, starting with the start cycle. On the MDU_CYCLES-th cycle (MDU, cnt 0), hold is released, EX_MEM captures the result, and load_use/redirect are evaluated normally.
- Load-use inserts exactly one bubble. The next cycle the load is in MEM and the condition clears on its own.
- Redirect during load_use or mdu_hold is deferred, not lost: the branch remains in ID and is re-evaluated.
- A memory wait that arises mid-MDU extends the MDU sequence by the wait length.
- Reset asserted in MDU returns the FSM to RUN immediately.
- err_o rises on the edge that ends the MEM_TIMEOUT-th consecutive wait cycle.

## Test plan
- Load-use: EX = lw $t0 (rt 8, memread 1), ID = add using rs 8 -> one cycle of pc_write 0, ifid_stall 1, idex_flush 1; next cycle all 0, pc_write 1. With rt_ex 0 -> no stall.
- Branch: branch_taken_i 1, no hazard -> ifid_flush 1, pc_write 1 for one cycle. Same branch coincident with load_use -> stall first, flush the following cycle.
- MDU, MDU_CYCLES 4: mdu_start_i held high for 4 cycles -> mdu_hold for 3 cycles (exmem_flush 1, pc_write 0), mdu_busy_o high in cycles 2–4, release in cycle 4, RUN in cycle 5.
- Memory wait in MDU: dmem_req 1, ready 0 for 2 cycles at MDU cnt 1 -> exmem_stall 1, memwb_flush 1, exmem_flush 0; cnt frozen; MDU completes 2 cycles late.
- Timeout, MEM_TIMEOUT 3: 3 consecutive wait cycles -> err_o 1 after the 3rd edge. After ready returns, err_o stays 1 until rst_i.
- Async reset mid-MDU: rst_i pulsed between edges -> outputs 0 immediately, mdu_busy_o 0, err_o 0.
